// File: rtl/l2_seq_pkg.sv
// l2_seq_pkg: shared types, constants and word-mask helper for the L2 flush/fence sequencer
package l2_seq_pkg;
  localparam logic [1:0] STATE_I = 2'd0;
  localparam logic [1:0] STATE_V = 2'd1;
  localparam logic [1:0] STATE_S = 2'd2;
  localparam logic [1:0] STATE_O = 2'd3;
  localparam int FENCE_REL = 0;
  localparam int FENCE_ACQ = 1;
  localparam int MAX_WORDS = 32;
  localparam int MAX_BITS = 2 * MAX_WORDS;
  typedef enum logic [2:0] {IDLE, READ, CHECK, WB, INV, NEXT, DRAIN, DONE} seq_state_t;
  typedef struct packed {
    logic [MAX_WORDS-1:0] o;
    logic [MAX_WORDS-1:0] v;
  } word_masks_t;
  function automatic word_masks_t get_masks(input logic [MAX_BITS-1:0] st);
    word_masks_t m;
    m = '0;
    for (int i = 0; i < MAX_WORDS; i++) begin
      m.o[i] = st[2*i+:2] == STATE_O;
      m.v[i] = st[2*i+:2] == STATE_V;
    end
    return m;
  endfunction
endpackage

// File: rtl/l2_seq_walk_cnt.sv
// l2_seq_walk_cnt: set/way walk counter with clear, increment and last-line flag
// i_clk/i_rst: clock, sync active-low reset; i_clr: zero the counter; i_inc: advance one line
// o_set/o_way: current line; o_last: current line is the final set/way
module l2_seq_walk_cnt #(
  parameter int N_SETS = 256,
  parameter int N_WAYS = 8,
  localparam int SET_W = $clog2(N_SETS),
  localparam int WAY_W = $clog2(N_WAYS)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [SET_W-1:0] o_set,
  output logic [WAY_W-1:0] o_way,
  output logic             o_last
);
  // way lives in the low bits so its wrap carries straight into the set
  logic [SET_W+WAY_W-1:0] r_cnt;
  always_ff @(posedge i_clk) begin
    if (!i_rst || i_clr) r_cnt <= '0;
    else if (i_inc) r_cnt <= r_cnt + 1'b1;
  end
  assign {o_set, o_way} = r_cnt;
  assign o_last = &r_cnt;
endmodule

// File: rtl/l2_flush_fence_seq.sv
// l2_flush_fence_seq: L2 flush / acquire / release fence sequencer walking every set and way
// i_flush_*/o_flush_ready, i_fence_*/o_fence_ready: request handshakes, accepted only when idle
// o_rd_*/i_rd_*: localmem line read (1-cycle latency); o_wr_*: line state write
// o_wb_*/i_wb_ready: owned-word writeback to the req-out arbiter
// i_mshr_cnt: outstanding MSHRs drained by release; o_busy, o_*_done: status and completion pulses
module l2_flush_fence_seq
  import l2_seq_pkg::*;
#(
  parameter int N_SETS = 256,
  parameter int N_WAYS = 8,
  parameter int N_WORDS = 4,
  parameter int TAG_W = 20,
  parameter int MSHR_CNT_W = 3,
  localparam int SET_W = $clog2(N_SETS),
  localparam int WAY_W = $clog2(N_WAYS)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_flush_valid,
  input  logic                   i_flush_all,
  output logic                   o_flush_ready,
  input  logic                   i_fence_valid,
  input  logic [1:0]             i_fence_kind,
  output logic                   o_fence_ready,
  input  logic [MSHR_CNT_W-1:0]  i_mshr_cnt,
  output logic                   o_rd_en,
  output logic [SET_W-1:0]       o_rd_set,
  output logic [WAY_W-1:0]       o_rd_way,
  input  logic [2*N_WORDS-1:0]   i_rd_state,
  input  logic [TAG_W-1:0]       i_rd_tag,
  input  logic                   i_rd_hprot,
  output logic                   o_wr_en,
  output logic [SET_W-1:0]       o_wr_set,
  output logic [WAY_W-1:0]       o_wr_way,
  output logic [2*N_WORDS-1:0]   o_wr_state,
  output logic                   o_wb_valid,
  input  logic                   i_wb_ready,
  output logic [TAG_W+SET_W-1:0] o_wb_addr,
  output logic [N_WORDS-1:0]     o_wb_word_mask,
  output logic                   o_busy,
  output logic                   o_flush_done,
  output logic                   o_fence_done
);
  seq_state_t r_state, w_next;
  logic r_flush, r_flush_all, r_fence;
  logic [1:0] r_kind;
  logic [TAG_W+SET_W-1:0] r_wb_addr;
  logic [N_WORDS-1:0] r_wb_mask;
  logic [2*N_WORDS-1:0] r_wr_state, w_acq_state;
  word_masks_t w_m;
  logic [N_WORDS-1:0] w_omask, w_vmask;
  logic w_unused, w_flush_acc, w_fence_acc, w_inc, w_clr, w_last;
  logic [SET_W-1:0] w_set;
  logic [WAY_W-1:0] w_way;
  l2_seq_walk_cnt #(.N_SETS(N_SETS), .N_WAYS(N_WAYS)) u_cnt (
    .i_clk(i_clk), .i_rst(i_rst), .i_clr(w_clr), .i_inc(w_inc),
    .o_set(w_set), .o_way(w_way), .o_last(w_last)
  );
  assign w_m = get_masks(MAX_BITS'(i_rd_state));
  assign w_omask = w_m.o[N_WORDS-1:0];
  assign w_vmask = w_m.v[N_WORDS-1:0];
  assign w_unused = |w_m;
  // flush wins a simultaneous request, so the fence only lands when no flush is offered
  assign w_flush_acc = r_state == IDLE && i_flush_valid;
  assign w_fence_acc = r_state == IDLE && i_fence_valid && !i_flush_valid;
  always_comb begin
    w_acq_state = i_rd_state;
    for (int i = 0; i < N_WORDS; i++) w_acq_state[2*i+:2] = w_vmask[i] ? STATE_I : i_rd_state[2*i+:2];
  end
  always_comb begin
    w_next = r_state;
    w_inc = 1'b0;
    w_clr = 1'b0;
    case (r_state)
      IDLE:  w_next = w_flush_acc ? READ :
                      !w_fence_acc ? IDLE :
                      i_fence_kind[FENCE_ACQ] ? READ :
                      i_fence_kind[FENCE_REL] ? DRAIN : DONE;
      READ:  w_next = CHECK;
      // a flush walk never carries an acquire, so the non-flush branch is the acquire rule
      CHECK: w_next = r_flush ? ((r_flush_all || i_rd_hprot) ? (|w_omask ? WB : |i_rd_state ? INV : NEXT) : NEXT)
                              : (|w_vmask ? INV : NEXT);
      WB:    w_next = i_wb_ready ? INV : WB;
      INV:   w_next = NEXT;
      NEXT: begin
        w_inc = 1'b1;
        w_next = !w_last ? READ : (r_fence && r_kind[FENCE_REL]) ? DRAIN : DONE;
      end
      DRAIN: w_next = i_mshr_cnt == '0 ? DONE : DRAIN;
      DONE: begin
        w_clr = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= IDLE;
      {r_flush, r_flush_all, r_fence, r_kind} <= '0;
      r_wb_addr <= '0;
      r_wb_mask <= '0;
      r_wr_state <= '0;
    end else begin
      r_state <= w_next;
      if (w_flush_acc) {r_flush, r_flush_all, r_fence, r_kind} <= {1'b1, i_flush_all, 3'b000};
      else if (w_fence_acc) {r_flush, r_flush_all, r_fence, r_kind} <= {3'b001, i_fence_kind};
      // read data is only valid in CHECK; capture it so WB/INV outputs stay stable
      if (r_state == CHECK) begin
        r_wb_addr <= {i_rd_tag, w_set};
        r_wb_mask <= w_omask;
        r_wr_state <= r_flush ? '0 : w_acq_state;
      end
    end
  end
  assign o_flush_ready = r_state == IDLE;
  assign o_fence_ready = r_state == IDLE && !i_flush_valid;
  assign o_rd_en = r_state == READ;
  assign o_rd_set = w_set;
  assign o_rd_way = w_way;
  assign o_wr_en = r_state == INV;
  assign o_wr_set = w_set;
  assign o_wr_way = w_way;
  assign o_wr_state = r_wr_state;
  assign o_wb_valid = r_state == WB;
  assign o_wb_addr = r_wb_addr;
  assign o_wb_word_mask = r_wb_mask;
  assign o_busy = r_state != IDLE;
  assign o_flush_done = r_state == DONE && r_flush;
  assign o_fence_done = r_state == DONE && r_fence;
endmodule

// File: tb/tb_l2_flush_fence_seq.sv
// tb_l2_flush_fence_seq: scoreboard bench for l2_flush_fence_seq (4 sets, 2 ways, 4 words)
module tb_l2_flush_fence_seq;
  logic clk = 1'b0, rst = 1'b0;
  logic flush_valid = 1'b0, flush_all = 1'b0, flush_ready;
  logic fence_valid = 1'b0, fence_ready;
  logic [1:0] fence_kind = 2'b00;
  logic [2:0] mshr_cnt = 3'd0;
  logic rd_en, wr_en, wb_valid, busy, flush_done, fence_done;
  logic wb_ready = 1'b0;
  logic [1:0] rd_set, wr_set;
  logic rd_way, wr_way;
  logic [7:0] rd_state = 8'h00, wr_state;
  logic [19:0] rd_tag = 20'h0;
  logic rd_hprot = 1'b0;
  logic [21:0] wb_addr;
  logic [3:0] wb_word_mask;
  always #5 clk = ~clk;
  l2_flush_fence_seq #(.N_SETS(4), .N_WAYS(2), .N_WORDS(4), .TAG_W(20), .MSHR_CNT_W(3)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_flush_valid(flush_valid), .i_flush_all(flush_all), .o_flush_ready(flush_ready),
    .i_fence_valid(fence_valid), .i_fence_kind(fence_kind), .o_fence_ready(fence_ready),
    .i_mshr_cnt(mshr_cnt),
    .o_rd_en(rd_en), .o_rd_set(rd_set), .o_rd_way(rd_way),
    .i_rd_state(rd_state), .i_rd_tag(rd_tag), .i_rd_hprot(rd_hprot),
    .o_wr_en(wr_en), .o_wr_set(wr_set), .o_wr_way(wr_way), .o_wr_state(wr_state),
    .o_wb_valid(wb_valid), .i_wb_ready(wb_ready), .o_wb_addr(wb_addr), .o_wb_word_mask(wb_word_mask),
    .o_busy(busy), .o_flush_done(flush_done), .o_fence_done(fence_done)
  );
  logic [7:0] mem_state [8];
  logic [19:0] mem_tag [8];
  logic mem_hprot [8];
  always @(posedge clk) if (rd_en) begin
    rd_state <= mem_state[{rd_set, rd_way}];
    rd_tag <= mem_tag[{rd_set, rd_way}];
    rd_hprot <= mem_hprot[{rd_set, rd_way}];
  end
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct { logic [21:0] a; logic [3:0] m; } wb_t;
  typedef struct { logic [2:0] idx; logic [7:0] st; } wr_t;
  wb_t q_wb[$];
  wr_t q_wr[$];
  logic [1:0] q_done[$];
  int n_chk = 0, n_pass = 0, n_rd = 0, n_done = 0, done_cyc = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask
  always @(negedge clk) begin : mon
    wr_t e;
    wb_t b;
    logic [1:0] d;
    #4;
    if (rd_en) n_rd++;
    if (wr_en) begin
      chk("wr_expected", q_wr.size() > 0, 1);
      if (q_wr.size() > 0) begin
        e = q_wr.pop_front();
        chk("wr_idx", {wr_set, wr_way}, e.idx);
        chk("wr_state", wr_state, e.st);
      end
    end
    if (wb_valid && wb_ready) begin
      chk("wb_expected", q_wb.size() > 0, 1);
      if (q_wb.size() > 0) begin
        b = q_wb.pop_front();
        chk("wb_addr", wb_addr, b.a);
        chk("wb_mask", wb_word_mask, b.m);
      end
    end
    if (flush_done || fence_done) begin
      n_done++;
      done_cyc = cyc;
      chk("done_expected", q_done.size() > 0, 1);
      if (q_done.size() > 0) begin
        d = q_done.pop_front();
        chk("done_kind", {flush_done, fence_done}, d);
      end
    end
  end
  task automatic clear_mem();
    for (int i = 0; i < 8; i++) begin
      mem_state[i] = 8'h00;
      mem_tag[i] = 20'h0;
      mem_hprot[i] = 1'b0;
    end
  endtask
  task automatic wait_idle(input string nm);
    int k = 0;
    while (busy && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_idle_timeout"}, k < 400, 1);
  endtask
  task automatic wait_wb(input string nm);
    int k = 0;
    while (!wb_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_wb_timeout"}, k < 200, 1);
  endtask
  task automatic start_flush(input logic all, output int t0);
    @(negedge clk);
    flush_valid = 1'b1;
    flush_all = all;
    #1 chk("flush_ready", flush_ready, 1);
    t0 = cyc;
    @(negedge clk);
    flush_valid = 1'b0;
  endtask
  task automatic start_fence(input logic [1:0] kind, output int t0);
    @(negedge clk);
    fence_valid = 1'b1;
    fence_kind = kind;
    #1 chk("fence_ready", fence_ready, 1);
    t0 = cyc;
    @(negedge clk);
    fence_valid = 1'b0;
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int t0, tz, n0, k;
    clear_mem();
    repeat (3) @(negedge clk);
    chk("rst_flush_ready", flush_ready, 1);
    chk("rst_fence_ready", fence_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rd_wr_wb", {rd_en, wr_en, wb_valid}, 0);
    chk("rst_done", {flush_done, fence_done}, 0);
    chk("rst_wb_addr_mask", {wb_addr, wb_word_mask}, 0);
    chk("rst_wr_state", wr_state, 0);
    rst = 1'b1;
    // all-invalid flush: 8 reads, no traffic, 3 cycles per line
    clear_mem();
    n0 = n_rd;
    q_done.push_back(2'b10);
    start_flush(1'b1, t0);
    wait_idle("t1");
    chk("t1_reads", n_rd - n0, 8);
    chk("t1_done_latency", done_cyc - t0, 25);
    // one owned line with back-pressure on the writeback
    clear_mem();
    mem_state[5] = 8'hD3;
    mem_tag[5] = 20'h12345;
    q_wb.push_back('{{20'h12345, 2'd2}, 4'b1001});
    q_wr.push_back('{3'd5, 8'h00});
    q_done.push_back(2'b10);
    start_flush(1'b1, t0);
    wait_wb("t2");
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_valid", wb_valid, 1);
      chk("t2_hold_addr", wb_addr, {20'h12345, 2'd2});
      chk("t2_hold_mask", wb_word_mask, 4'b1001);
      @(negedge clk);
    end
    wb_ready = 1'b1;
    wait_idle("t2");
    wb_ready = 1'b0;
    // acquire fence self-invalidates V words only
    clear_mem();
    mem_state[0] = 8'h6D;
    mem_state[3] = 8'hBE;
    q_wr.push_back('{3'd0, 8'h2C});
    q_done.push_back(2'b01);
    n0 = n_rd;
    start_fence(2'b10, t0);
    wait_idle("t3");
    chk("t3_reads", n_rd - n0, 8);
    // release fence drains MSHRs without reading
    clear_mem();
    mshr_cnt = 3'd3;
    q_done.push_back(2'b01);
    n0 = n_rd;
    start_fence(2'b01, t0);
    chk("t4_busy_drain", busy, 1);
    for (int i = 0; i < 3; i++) begin
      repeat (4) @(negedge clk);
      mshr_cnt = mshr_cnt - 3'd1;
    end
    tz = cyc;
    wait_idle("t4");
    chk("t4_reads", n_rd - n0, 0);
    chk("t4_done_latency", done_cyc - tz, 1);
    // empty fence kind completes right away
    q_done.push_back(2'b01);
    start_fence(2'b00, t0);
    wait_idle("t4b");
    chk("t4b_done_latency", done_cyc - t0, 1);
    // simultaneous flush and fence: flush first, fence after flush_done
    clear_mem();
    q_done.push_back(2'b10);
    q_done.push_back(2'b01);
    @(negedge clk);
    flush_valid = 1'b1;
    flush_all = 1'b1;
    fence_valid = 1'b1;
    fence_kind = 2'b10;
    #1 chk("t5_flush_ready", flush_ready, 1);
    chk("t5_fence_ready_blocked", fence_ready, 0);
    @(negedge clk);
    flush_valid = 1'b0;
    #1 chk("t5_fence_ready_busy", fence_ready, 0);
    chk("t5_busy", busy, 1);
    k = 0;
    while (!fence_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("t5_fence_wait_timeout", k < 200, 1);
    chk("t5_fence_after_flush_done", cyc - done_cyc, 1);
    @(negedge clk);
    fence_valid = 1'b0;
    wait_idle("t5");
    // reset mid-writeback: straight to idle, no done pulse
    clear_mem();
    mem_state[5] = 8'hD3;
    mem_tag[5] = 20'h12345;
    n0 = n_done;
    start_flush(1'b1, t0);
    wait_wb("t6");
    rst = 1'b0;
    @(negedge clk);
    chk("t6_busy", busy, 0);
    chk("t6_wb_valid", wb_valid, 0);
    chk("t6_flush_ready", flush_ready, 1);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    chk("t6_no_done", n_done - n0, 0);
    // data-only flush skips hprot=0 lines
    clear_mem();
    mem_state[1] = 8'hFF;
    mem_tag[1] = 20'h11111;
    mem_state[4] = 8'hC0;
    mem_state[2] = 8'h42;
    mem_hprot[2] = 1'b1;
    mem_state[6] = 8'h0E;
    mem_hprot[6] = 1'b1;
    mem_tag[6] = 20'hABCDE;
    q_wr.push_back('{3'd2, 8'h00});
    q_wr.push_back('{3'd6, 8'h00});
    q_wb.push_back('{{20'hABCDE, 2'd3}, 4'b0010});
    q_done.push_back(2'b10);
    wb_ready = 1'b1;
    start_flush(1'b0, t0);
    wait_idle("t7");
    wb_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("end_wr_queue", q_wr.size(), 0);
    chk("end_wb_queue", q_wb.size(), 0);
    chk("end_done_queue", q_done.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
